axi_lite_mem_responder: RTL and testbench

AXI_LITE_MEM_RESPONDER -- requirements
Module: axi_lite_mem_responder

---
 rtl/axi_lite_mem_pkg.sv | 25 ++
 rtl/axi_lite_mem_array.sv | 48 ++++
 rtl/axi_lite_mem_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_lite_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_pkg
// Shared constants for the AXI-Lite memory responder: the two response codes
// this slave can return, and the state encodings of its independent write and
// read channel state machines.
// ---------------------------------------------------------------------------
package axi_lite_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi_lite_mem_array.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_array
// Word-organised storage with per-byte write enables and a registered read
// port. Contents are deliberately not reset so that data survives a bus reset.
//
// Ports:
//   clk_i     single clock
//   we_i      write enable for the word at waddr_i
//   waddr_i   write word index
//   wdata_i   write data
//   wstrb_i   byte lane enables, one per byte of wdata_i
//   re_i      read enable; rdata_o updates only when this is high
//   raddr_i   read word index
//   rdata_o   registered read data (holds between reads)
// ---------------------------------------------------------------------------
module axi_lite_mem_array
    import axi_lite_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] memWords_q [MEM_WORDS];

    // Read and write share one edge; the read picks up the value from before
    // any write landing on the same word in the same cycle.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= memWords_q[raddr_i];
        end
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (we_i && wstrb_i[b]) begin
                memWords_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_responder
// AXI-Lite slave backed by a local memory. One write and one read may be in
// flight at a time, handled by two independent state machines. Addresses
// outside [BASE_ADDR, BASE_ADDR + MEM_WORDS words) return SLVERR and never
// touch storage. Reads answer a fixed READ_LATENCY cycles after AR.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   aw*/w*/b*                         write address, data, response channels
//   ar*/r*                            read address and data channels
//   wr_count_o, rd_count_o            completed transactions, saturating
// ---------------------------------------------------------------------------
module axi_lite_mem_responder
    import axi_lite_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    MEM_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    READ_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [31:0]             wr_count_o,
    output logic [31:0]             rd_count_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);

    // Full-width word index so an address past the end is not folded back
    // onto a low word before the range check sees it.
    function automatic logic [ADDR_WIDTH-1:0] wordIndex(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> OFF_BITS;
    endfunction

    function automatic logic addrInRange(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && (wordIndex(addr) < MEM_WORDS_A);
    endfunction

    function automatic logic [IDX_W-1:0] memIndex(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(wordIndex(addr));
    endfunction

    wr_state_e               wrState_q, wrState_d;
    logic [ADDR_WIDTH-1:0]   awAddr_q, awAddr_d;
    logic [DATA_WIDTH-1:0]   wData_q, wData_d;
    logic [STRB_WIDTH-1:0]   wStrb_q, wStrb_d;
    logic [1:0]              bResp_q, bResp_d;
    logic [31:0]             wrCount_q, wrCount_d;

    rd_state_e               rdState_q, rdState_d;
    logic [ADDR_WIDTH-1:0]   arAddr_q, arAddr_d;
    logic [3:0]              latCnt_q, latCnt_d;
    logic [1:0]              rResp_q, rResp_d;
    logic [31:0]             rdCount_q, rdCount_d;

    logic                    commit;
    logic                    memWe;
    logic [ADDR_WIDTH-1:0]   commitAddr;
    logic [DATA_WIDTH-1:0]   commitData;
    logic [STRB_WIDTH-1:0]   commitStrb;

    logic                    enterResp;
    logic                    memRe;
    logic [ADDR_WIDTH-1:0]   sampleAddr;
    logic [DATA_WIDTH-1:0]   memRdata;

    // Write channel: whichever of AW/W arrives first is parked in a register;
    // the write commits in the cycle the second half handshakes, taking each
    // half either from the register or straight from the bus.
    always_comb begin
        wrState_d  = wrState_q;
        awAddr_d   = awAddr_q;
        wData_d    = wData_q;
        wStrb_d    = wStrb_q;
        bResp_d    = bResp_q;
        wrCount_d  = wrCount_q;
        commit     = 1'b0;
        memWe      = 1'b0;
        commitAddr = awaddr_i;
        commitData = wdata_i;
        commitStrb = wstrb_i;
        case (wrState_q)
            WR_IDLE: begin
                if (awvalid_i && wvalid_i) begin
                    commit = 1'b1;
                end else if (awvalid_i) begin
                    awAddr_d  = awaddr_i;
                    wrState_d = WR_HAVE_AW;
                end else if (wvalid_i) begin
                    wData_d   = wdata_i;
                    wStrb_d   = wstrb_i;
                    wrState_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                commitAddr = awAddr_q;
                commit     = wvalid_i;
            end
            WR_HAVE_W: begin
                commitData = wData_q;
                commitStrb = wStrb_q;
                commit     = awvalid_i;
            end
            WR_RESP: begin
                if (bready_i) begin
                    wrState_d = WR_IDLE;
                    if (wrCount_q != 32'hFFFF_FFFF) begin
                        wrCount_d = wrCount_q + 32'd1;
                    end
                end
            end
            default: wrState_d = WR_IDLE;
        endcase
        if (commit) begin
            memWe     = addrInRange(commitAddr);
            bResp_d   = addrInRange(commitAddr) ? RESP_OKAY : RESP_SLVERR;
            wrState_d = WR_RESP;
        end
    end

    // Read channel: the latency counter runs down in RD_WAIT; storage is
    // sampled on the edge that moves the FSM into RD_RESP, so the array's
    // output register then holds the response data until the handshake.
    always_comb begin
        rdState_d  = rdState_q;
        arAddr_d   = arAddr_q;
        latCnt_d   = latCnt_q;
        rResp_d    = rResp_q;
        rdCount_d  = rdCount_q;
        enterResp  = 1'b0;
        memRe      = 1'b0;
        sampleAddr = arAddr_q;
        case (rdState_q)
            RD_IDLE: begin
                sampleAddr = araddr_i;
                if (arvalid_i) begin
                    arAddr_d = araddr_i;
                    if (READ_LATENCY <= 1) begin
                        enterResp = 1'b1;
                    end else begin
                        latCnt_d  = 4'(READ_LATENCY - 1);
                        rdState_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (latCnt_q <= 4'd1) begin
                    enterResp = 1'b1;
                end else begin
                    latCnt_d = latCnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (rready_i) begin
                    rdState_d = RD_IDLE;
                    if (rdCount_q != 32'hFFFF_FFFF) begin
                        rdCount_d = rdCount_q + 32'd1;
                    end
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
        if (enterResp) begin
            memRe     = addrInRange(sampleAddr);
            rResp_d   = addrInRange(sampleAddr) ? RESP_OKAY : RESP_SLVERR;
            rdState_d = RD_RESP;
        end
    end

    // All channel state; storage itself lives in the array and is not reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrState_q <= WR_IDLE;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bResp_q   <= RESP_OKAY;
            wrCount_q <= '0;
            rdState_q <= RD_IDLE;
            arAddr_q  <= '0;
            latCnt_q  <= '0;
            rResp_q   <= RESP_OKAY;
            rdCount_q <= '0;
        end else begin
            wrState_q <= wrState_d;
            awAddr_q  <= awAddr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            bResp_q   <= bResp_d;
            wrCount_q <= wrCount_d;
            rdState_q <= rdState_d;
            arAddr_q  <= arAddr_d;
            latCnt_q  <= latCnt_d;
            rResp_q   <= rResp_d;
            rdCount_q <= rdCount_d;
        end
    end

    axi_lite_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) memArray (
        .clk_i   (clk_i),
        .we_i    (memWe),
        .waddr_i (memIndex(commitAddr)),
        .wdata_i (commitData),
        .wstrb_i (commitStrb),
        .re_i    (memRe),
        .raddr_i (memIndex(sampleAddr)),
        .rdata_o (memRdata)
    );

    assign awready_o  = (wrState_q == WR_IDLE) || (wrState_q == WR_HAVE_W);
    assign wready_o   = (wrState_q == WR_IDLE) || (wrState_q == WR_HAVE_AW);
    assign bvalid_o   = (wrState_q == WR_RESP);
    assign bresp_o    = bResp_q;
    assign arready_o  = (rdState_q == RD_IDLE);
    assign rvalid_o   = (rdState_q == RD_RESP);
    assign rresp_o    = rResp_q;
    // Error responses and idle periods present zero data.
    assign rdata_o    = (rvalid_o && rResp_q == RESP_OKAY) ? memRdata : '0;
    assign wr_count_o = wrCount_q;
    assign rd_count_o = rdCount_q;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_responder
// Directed scenarios plus a randomized write/read phase for the AXI-Lite
// memory responder, compared against a word-array reference model.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_responder;

    localparam int          READ_LATENCY = 2;
    localparam logic [31:0] BASE         = 32'h8000_0000;
    localparam int          WORDS        = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] wrCount;
    logic [31:0] rdCount;

    int nChecks = 0;
    int nBad    = 0;
    int expWr   = 0;
    int expRd   = 0;

    logic [63:0] refMem [WORDS];
    bit          refWritten [WORDS];

    axi_lite_mem_responder #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (64),
        .MEM_WORDS    (WORDS),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .awaddr_i   (awaddr),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .bresp_o    (bresp),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .araddr_i   (araddr),
        .arvalid_i  (arvalid),
        .arready_o  (arready),
        .rdata_o    (rdata),
        .rresp_o    (rresp),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .wr_count_o (wrCount),
        .rd_count_o (rdCount)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: addressing and byte-strobe rules in plain arithmetic
    function automatic bit refInRange(input logic [31:0] addr);
        return (addr >= BASE) && (((addr - BASE) / 8) < WORDS);
    endfunction

    function automatic int refIndex(input logic [31:0] addr);
        return int'((addr - BASE) / 8);
    endfunction

    function automatic void refWrite(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int idx;
        if (!refInRange(addr)) return;
        idx = refIndex(addr);
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) refMem[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        refWritten[idx] = 1'b1;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two cycles, checking every reset value, then release
    task automatic applyReset();
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("rstBvalid",  bvalid,  0);
        checkOutput("rstRvalid",  rvalid,  0);
        checkOutput("rstBresp",   bresp,   0);
        checkOutput("rstRresp",   rresp,   0);
        checkOutput("rstRdata",   rdata,   0);
        checkOutput("rstAwready", awready, 1);
        checkOutput("rstWready",  wready,  1);
        checkOutput("rstArready", arready, 1);
        checkOutput("rstWrCount", wrCount, 0);
        checkOutput("rstRdCount", rdCount, 0);
        rst_n = 1'b1;
        expWr = 0;
        expRd = 0;
        nextCycle();
    endtask

    // One full write: AW and W raised after independent delays, then B held
    // for bStall cycles before bready
    task automatic writeTxn(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int awDelay, input int wDelay, input int bStall);
        bit awDone = 0, wDone = 0, awHs, wHs, stable = 1;
        int t = 0;
        logic [1:0] expResp;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(awDone && wDone) && t < 50) begin
            awvalid = !awDone && (t >= awDelay);
            wvalid  = !wDone && (t >= wDelay);
            awHs = awvalid && awready;
            wHs  = wvalid && wready;
            nextCycle();
            if (awHs) awDone = 1;
            if (wHs)  wDone = 1;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("wrHandshake", {awDone, wDone}, 2'b11);
        expResp = refInRange(addr) ? 2'b00 : 2'b10;
        refWrite(addr, data, strb);
        checkOutput("bvalidRise", bvalid, 1);
        checkOutput("bresp", bresp, expResp);
        checkOutput("awreadyInResp", {awready, wready}, 2'b00);
        for (int i = 0; i < bStall; i++) begin
            nextCycle();
            if (bvalid !== 1'b1 || bresp !== expResp || awready !== 1'b0 || wready !== 1'b0) stable = 0;
        end
        checkOutput("bHold", stable, 1);
        bready = 1'b1;
        nextCycle();
        bready = 1'b0;
        expWr++;
        checkOutput("bvalidFall", bvalid, 0);
    endtask

    // One full read: AR, latency measurement, R held for rStall cycles
    task automatic readTxn(input logic [31:0] addr, input int rStall);
        int lat = 1;
        bit stable = 1;
        logic [1:0]  expResp;
        logic [63:0] expData;
        araddr  = addr;
        arvalid = 1'b1;
        checkOutput("arready", arready, 1);
        nextCycle();
        arvalid = 1'b0;
        while (!rvalid && lat < 40) begin
            nextCycle();
            lat++;
        end
        checkOutput("rdLatency", lat, READ_LATENCY);
        if (refInRange(addr)) begin
            expResp = 2'b00;
            expData = refMem[refIndex(addr)];
        end else begin
            expResp = 2'b10;
            expData = '0;
        end
        checkOutput("rresp", rresp, expResp);
        checkOutput("rdata", rdata, expData);
        checkOutput("arreadyInResp", arready, 0);
        for (int i = 0; i < rStall; i++) begin
            nextCycle();
            if (rvalid !== 1'b1 || rdata !== expData || rresp !== expResp || arready !== 1'b0) stable = 0;
        end
        checkOutput("rHold", stable, 1);
        rready = 1'b1;
        nextCycle();
        rready = 1'b0;
        expRd++;
        checkOutput("rvalidFall", rvalid, 0);
    endtask

    // Randomized phase: writes over a small word window (so words get
    // overwritten with partial strobes), then reads back random written words
    task automatic applyStimulus(input int nTxn);
        int idxList [$];
        for (int n = 0; n < nTxn; n++) begin
            int idx = int'($urandom_range(0, 63));
            logic [31:0] addr = BASE + 32'(idx * 8) + 32'($urandom_range(0, 7));
            logic [63:0] data = {$urandom, $urandom};
            logic [7:0]  strb = refWritten[idx] ? 8'($urandom) : 8'hFF;
            writeTxn(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            idxList.push_back(idx);
        end
        for (int n = 0; n < nTxn; n++) begin
            int idx = idxList[$urandom_range(0, idxList.size() - 1)];
            readTxn(BASE + 32'(idx * 8) + 32'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        bit quiet = 1;
        $display("[TB] start");
        applyReset();

        // AW first, W two cycles later; then read back with fixed latency
        writeTxn(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 2, 0);
        readTxn(32'h8000_0010, 0);

        // AW and W together with a partial strobe
        writeTxn(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 0);
        readTxn(32'h8000_0010, 0);
        checkOutput("strbMerge", refMem[2], 64'h1122_3344_FFFF_FFFF);

        // W before AW, to word 0
        writeTxn(32'h8000_0000, 64'hA5A5_0000_DEAD_BEEF, 8'hFF, 3, 0, 0);
        readTxn(32'h8000_0000, 0);

        // Out-of-range write below base and one word past the end (which
        // would alias word 0 if the range check were missing)
        writeTxn(32'h7FFF_FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0);
        writeTxn(32'h8000_2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 0, 0);
        readTxn(32'h8000_2000, 0);
        readTxn(32'h8000_0000, 0);
        readTxn(32'h8000_0010, 0);

        // Response back-pressure for five cycles on both channels
        writeTxn(32'h8000_0020, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0, 1, 5);
        readTxn(32'h8000_0020, 5);
        checkOutput("wrCount", wrCount, 32'(expWr));
        checkOutput("rdCount", rdCount, 32'(expRd));

        // Reset while a write holds only AW and a read is waiting for latency
        awaddr = 32'h8000_0010; awvalid = 1'b1;
        araddr = 32'h8000_0000; arvalid = 1'b1;
        nextCycle();
        awvalid = 1'b0; arvalid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        expWr = 0;
        expRd = 0;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) quiet = 0;
        end
        checkOutput("abortQuiet", quiet, 1);
        checkOutput("abortWrCount", wrCount, 0);
        checkOutput("abortRdCount", rdCount, 0);
        readTxn(32'h8000_0010, 0);
        readTxn(32'h8000_0000, 0);

        // Randomized traffic from a clean reset
        applyReset();
        applyStimulus(100);
        checkOutput("finalWrCount", wrCount, 32'd100);
        checkOutput("finalRdCount", rdCount, 32'd100);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
